id_ex_reg: RTL
==============

// Module: id_ex_reg
// PURPOSE
// - ID->EX pipeline register of the P8 datapath. It captures the decoded ID-stage bundle at the clock edge:
//   - the sign/zero/upper-extended immediate produced by the immediate extender;
//   - the register-file read data;
//   - the destination register address and the control word.
// - It presents the bundle to EX for one cycle.
// - It implements freeze (hold), bubble (NOP insertion for load-use hazards) and flush (exception/eret kill).
// PARAMETERS
// - CTRL_W   12   width of the EX/MEM/WB control word carried down the pipe
// - PC_W     32   program-counter width
// PORTS
// - clk          in   1       rising-edge clock
// - reset        in   1       asynchronous, active-high reset
// - flush        in   1       kill the ID instruction; EX receives a bubble next cycle
// - freeze       in   1       hold all EX-stage contents (MDU busy / downstream stall)
// - bubble       in   1       load-use hazard from the hazard unit; EX receives a bubble, ID holds
// - id_valid     in   1       the ID stage holds a real instruction
// - id_pc        in   PC_W    PC of the ID instruction
// - id_instr     in   32      raw instruction word
// - id_rs_data   in   32      GPR[rs] read data, already forwarded
// - id_rt_data   in   32      GPR[rt] read data, already forwarded
// - id_imm32     in   32      extended immediate from the extender
// - id_wr_addr   in   5       destination GPR; 0 means no write
// - id_ctrl      in   CTRL_W  control word
// - ex_valid     out  1       the EX stage holds a real instruction
// - ex_pc        out  PC_W    registered id_pc
// - ex_instr     out  32      registered id_instr
// - ex_rs_data   out  32      registered id_rs_data
// - ex_rt_data   out  32      registered id_rt_data
// - ex_imm32     out  32      registered id_imm32
// - ex_shamt     out  5       registered id_instr[10:6]
// - ex_rs_addr   out  5       registered id_instr[25:21], for EX forwarding
// - ex_rt_addr   out  5       registered id_instr[20:16], for EX forwarding
// - ex_wr_addr   out  5       registered id_wr_addr
// - ex_ctrl      out  CTRL_W  registered id_ctrl
// BEHAVIOUR
// - Reset (asynchronous, active-high): every output is 0. ex_instr = 32'h0000_0000 (sll $0,$0,0), ex_valid = 0.
// - Latency: exactly 1 cycle from an ID value to its EX value. There is no combinational path from inputs to outputs.
// - Per-edge priority: reset > flush > freeze > bubble > load.
// - flush: load the NOP bundle, even when freeze is asserted. A killed instruction must never survive.
// - freeze (no flush): all registers keep their current value. Any bubble request this cycle is ignored.
// - bubble (no flush, no freeze): load the NOP bundle. The ID stage holds the stalled instruction externally.
// - load: capture all id_* inputs. ex_valid <= id_valid.
// - id_valid = 0 on a load: capture the NOP bundle. ex_valid and ex_wr_addr are then 0.
// - NOP bundle contents:
//   - ex_valid = 0, ex_instr = 0, ex_ctrl = 0, ex_wr_addr = 0, ex_imm32 = 0, ex_shamt = 0, ex_rs_addr = 0, ex_rt_addr = 0;
//   - ex_pc = id_pc, kept so the EPC is correct for a delay slot;
//   - ex_rs_data = 0, ex_rt_data = 0.
// - Invariant: ex_valid = 0 implies ex_wr_addr = 0 and ex_ctrl = 0. Hazard and forwarding logic rely on this.
// - Fields are captured bit-exact: no extension or truncation. ex_imm32 is the extender output unchanged.
// - Reset deasserted mid-stream: the first edge after release performs a normal load.
// CONFIGURATION
// - ID_EX_EXC_EN defined adds these ports:
//   - inputs: id_exc[4:0] (ExcCode, 0 = none) and id_bd (delay-slot flag);
//   - outputs: ex_exc and ex_bd.
// - ID_EX_EXC_EN behaviour:
//   - ex_exc and ex_bd obey the same priority rules as the other fields;
//   - NOP bundle: ex_exc = 0, and ex_bd keeps id_bd;
//   - a captured id_exc != 0 forces ex_ctrl = 0 and ex_wr_addr = 0, so a faulting instruction has no side effects.
// - ID_EX_EXC_EN undefined: none of these ports exist, and exception state is carried elsewhere.
// STRUCTURE
// - Shared package cpu_pkg: CTRL_W, NOP_INSTR (32'h0), EXC_* codes, and field-slice localparams (RS_MSB/LSB, RT_*, SHAMT_*).
// - Sub-module pipe_field #(W) holds one field: ports clk, reset, en, clr, d, q.
//   - One instance per field.
//   - en = ~freeze | flush.
//   - clr = flush | bubble | ~id_valid. For ex_pc: clr tied 0.
// TESTING
// - Reset: assert reset mid-cycle -> all ex_* outputs are 0 immediately, with no clock edge.
// - Load: id_valid=1, id_imm32=32'hFFFF_8000, id_wr_addr=5'd8, id_ctrl=12'h0A5 -> next edge gives ex_imm32=32'hFFFF_8000, ex_wr_addr=8, ex_valid=1.
// - Freeze: freeze=1 for 3 cycles while id_* changes -> ex_* stays stable at the prior bundle. On release, the next edge loads the current id_*.
// - Bubble: bubble=1, id_valid=1, id_wr_addr=9 -> next cycle ex_valid=0, ex_wr_addr=0, ex_ctrl=0, ex_pc=id_pc.
// - Flush + freeze together: flush=1, freeze=1 -> NOP bundle loads, so flush wins. With freeze+bubble together, contents hold.
// - ID_EX_EXC_EN: id_exc=5'd10 (RI), id_wr_addr=3 -> ex_exc=10, ex_wr_addr=0, ex_ctrl=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared P8 datapath constants: control-word width, NOP encoding, ExcCodes
// and instruction field positions.
package cpu_pkg;

  localparam int unsigned CTRL_W    = 12;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned EXC_W     = 5;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;

  function automatic logic [REG_AW-1:0] rs_of(input logic [INSTR_W-1:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] rt_of(input logic [INSTR_W-1:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] shamt_of(input logic [INSTR_W-1:0] instr);
    return instr[SHAMT_MSB:SHAMT_LSB];
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID->EX bundle interface: pipeline controls, ID-side inputs and EX-side outputs.
// ID_EX_EXC_EN adds the exception code and delay-slot flag.
interface id_ex_reg_if
  import cpu_pkg::*;
#(
  parameter int unsigned P_CTRL_W = cpu_pkg::CTRL_W,
  parameter int unsigned P_PC_W   = cpu_pkg::PC_W
);

  logic                flush;
  logic                freeze;
  logic                bubble;
  logic                id_valid;
  logic [P_PC_W-1:0]   id_pc;
  logic [INSTR_W-1:0]  id_instr;
  logic [DATA_W-1:0]   id_rs_data;
  logic [DATA_W-1:0]   id_rt_data;
  logic [DATA_W-1:0]   id_imm32;
  logic [REG_AW-1:0]   id_wr_addr;
  logic [P_CTRL_W-1:0] id_ctrl;

  logic                ex_valid;
  logic [P_PC_W-1:0]   ex_pc;
  logic [INSTR_W-1:0]  ex_instr;
  logic [DATA_W-1:0]   ex_rs_data;
  logic [DATA_W-1:0]   ex_rt_data;
  logic [DATA_W-1:0]   ex_imm32;
  logic [REG_AW-1:0]   ex_shamt;
  logic [REG_AW-1:0]   ex_rs_addr;
  logic [REG_AW-1:0]   ex_rt_addr;
  logic [REG_AW-1:0]   ex_wr_addr;
  logic [P_CTRL_W-1:0] ex_ctrl;

`ifdef ID_EX_EXC_EN
  logic [EXC_W-1:0]    id_exc;
  logic                id_bd;
  logic [EXC_W-1:0]    ex_exc;
  logic                ex_bd;

  modport master (
    output flush, freeze, bubble, id_valid, id_pc, id_instr, id_rs_data,
           id_rt_data, id_imm32, id_wr_addr, id_ctrl, id_exc, id_bd,
    input  ex_valid, ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm32,
           ex_shamt, ex_rs_addr, ex_rt_addr, ex_wr_addr, ex_ctrl, ex_exc, ex_bd
  );

  modport slave (
    input  flush, freeze, bubble, id_valid, id_pc, id_instr, id_rs_data,
           id_rt_data, id_imm32, id_wr_addr, id_ctrl, id_exc, id_bd,
    output ex_valid, ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm32,
           ex_shamt, ex_rs_addr, ex_rt_addr, ex_wr_addr, ex_ctrl, ex_exc, ex_bd
  );
`else
  modport master (
    output flush, freeze, bubble, id_valid, id_pc, id_instr, id_rs_data,
           id_rt_data, id_imm32, id_wr_addr, id_ctrl,
    input  ex_valid, ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm32,
           ex_shamt, ex_rs_addr, ex_rt_addr, ex_wr_addr, ex_ctrl
  );

  modport slave (
    input  flush, freeze, bubble, id_valid, id_pc, id_instr, id_rs_data,
           id_rt_data, id_imm32, id_wr_addr, id_ctrl,
    output ex_valid, ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm32,
           ex_shamt, ex_rs_addr, ex_rt_addr, ex_wr_addr, ex_ctrl
  );
`endif

endinterface

// File: rtl/pipe_field.sv
// One pipeline-register field: hold when en=0, load zero when clr=1, else load d.
module pipe_field #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= clr ? '0 : d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register with freeze / bubble / flush (flush > freeze > bubble > load).
// ID_EX_EXC_EN adds ex_exc/ex_bd; a faulting instruction is captured without ctrl or write-back.
module id_ex_reg
  import cpu_pkg::*;
#(
  parameter int unsigned P_CTRL_W = cpu_pkg::CTRL_W,
  parameter int unsigned P_PC_W   = cpu_pkg::PC_W
) (
  input  logic        clk,
  input  logic        reset,
  id_ex_reg_if.slave  bus
);

  logic                w_en;
  logic                w_clr;
  logic                w_clr_kill;

  logic                w_ex_valid;
  logic [P_PC_W-1:0]   w_ex_pc;
  logic [INSTR_W-1:0]  w_ex_instr;
  logic [DATA_W-1:0]   w_ex_rs_data;
  logic [DATA_W-1:0]   w_ex_rt_data;
  logic [DATA_W-1:0]   w_ex_imm32;
  logic [REG_AW-1:0]   w_ex_shamt;
  logic [REG_AW-1:0]   w_ex_rs_addr;
  logic [REG_AW-1:0]   w_ex_rt_addr;
  logic [REG_AW-1:0]   w_ex_wr_addr;
  logic [P_CTRL_W-1:0] w_ex_ctrl;

  // Flush overrides freeze so a killed instruction can never be held in EX.
  assign w_en  = ~bus.freeze | bus.flush;
  assign w_clr = bus.flush | bus.bubble | ~bus.id_valid;

`ifdef ID_EX_EXC_EN
  logic [EXC_W-1:0] w_ex_exc;
  logic             w_ex_bd;

  assign w_clr_kill = w_clr | (bus.id_exc != EXC_NONE);

  pipe_field #(.W(EXC_W)) u_exc (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr), .d(bus.id_exc), .q(w_ex_exc));
  pipe_field #(.W(1))     u_bd  (.clk(clk), .reset(reset), .en(w_en), .clr(1'b0),  .d(bus.id_bd),  .q(w_ex_bd));

  assign bus.ex_exc = w_ex_exc;
  assign bus.ex_bd  = w_ex_bd;
`else
  assign w_clr_kill = w_clr;
`endif

  pipe_field #(.W(1))        u_valid   (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr),      .d(bus.id_valid),          .q(w_ex_valid));
  // PC survives NOP insertion so EPC stays correct for a delay slot.
  pipe_field #(.W(P_PC_W))   u_pc      (.clk(clk), .reset(reset), .en(w_en), .clr(1'b0),       .d(bus.id_pc),             .q(w_ex_pc));
  pipe_field #(.W(INSTR_W))  u_instr   (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr),      .d(bus.id_instr),          .q(w_ex_instr));
  pipe_field #(.W(DATA_W))   u_rs_data (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr),      .d(bus.id_rs_data),        .q(w_ex_rs_data));
  pipe_field #(.W(DATA_W))   u_rt_data (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr),      .d(bus.id_rt_data),        .q(w_ex_rt_data));
  pipe_field #(.W(DATA_W))   u_imm32   (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr),      .d(bus.id_imm32),          .q(w_ex_imm32));
  pipe_field #(.W(REG_AW))   u_shamt   (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr),      .d(shamt_of(bus.id_instr)), .q(w_ex_shamt));
  pipe_field #(.W(REG_AW))   u_rs_addr (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr),      .d(rs_of(bus.id_instr)),   .q(w_ex_rs_addr));
  pipe_field #(.W(REG_AW))   u_rt_addr (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr),      .d(rt_of(bus.id_instr)),   .q(w_ex_rt_addr));
  pipe_field #(.W(REG_AW))   u_wr_addr (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr_kill), .d(bus.id_wr_addr),        .q(w_ex_wr_addr));
  pipe_field #(.W(P_CTRL_W)) u_ctrl    (.clk(clk), .reset(reset), .en(w_en), .clr(w_clr_kill), .d(bus.id_ctrl),           .q(w_ex_ctrl));

  assign bus.ex_valid   = w_ex_valid;
  assign bus.ex_pc      = w_ex_pc;
  assign bus.ex_instr   = w_ex_instr;
  assign bus.ex_rs_data = w_ex_rs_data;
  assign bus.ex_rt_data = w_ex_rt_data;
  assign bus.ex_imm32   = w_ex_imm32;
  assign bus.ex_shamt   = w_ex_shamt;
  assign bus.ex_rs_addr = w_ex_rs_addr;
  assign bus.ex_rt_addr = w_ex_rt_addr;
  assign bus.ex_wr_addr = w_ex_wr_addr;
  assign bus.ex_ctrl    = w_ex_ctrl;

endmodule
